// File: rtl/ceg_pkg.sv
// rtl/ceg_pkg.sv - shared types, mode encodings and sizing helper for count_enable_gen
package ceg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    RELEASE = 2'd2
  } ceg_state_t;

  localparam logic MODE_PRESCALE = 1'b0;
  localparam logic MODE_EVENT    = 1'b1;

  function automatic int deb_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/count_enable_gen_sync.sv
// rtl/count_enable_gen_sync.sv - bit_synchronizer: multi-flop synchronizer, async-cleared to 0
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/count_enable_gen.sv
// rtl/count_enable_gen.sv - counter enable pulse from a prescaler or a debounced external event
// Optional sticky missed-event flag built only when CEG_MISSED_EVENT_EN is defined.
module count_enable_gen
  import ceg_pkg::*;
#(
  parameter int PRESCALE_W      = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  event_in,
  output logic                  tick_out,
  output logic                  missed
);

  localparam int              DEB_W    = deb_w(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  ceg_state_t             state, state_d;
  logic [DEB_W-1:0]       deb_cnt, deb_d;
  logic [PRESCALE_W-1:0]  div_cnt, div_d;
  logic                   mode_q;
  logic                   ev_s;
  logic                   tick_d;
  logic                   qual;
  logic                   mode_chg;
  logic                   deb_at_last;
  logic [DEB_W-1:0]       deb_inc;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .clear (clear),
    .d     (event_in),
    .q     (ev_s)
  );

  assign mode_chg    = (mode != mode_q);
  assign deb_at_last = (deb_cnt == DEB_LAST);
  assign deb_inc     = deb_cnt + DEB_W'(1);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      deb_cnt  <= '0;
      div_cnt  <= '0;
      mode_q   <= MODE_PRESCALE;
      tick_out <= 1'b0;
    end else begin
      state    <= state_d;
      deb_cnt  <= deb_d;
      div_cnt  <= div_d;
      mode_q   <= mode;
      tick_out <= tick_d;
    end
  end

  // IDLE and QUAL share one path: deb_cnt is always 0 in IDLE, so a single
  // debounce cycle qualifies straight from IDLE.
  always_comb begin
    state_d = state;
    deb_d   = deb_cnt;
    if (mode_chg || mode == MODE_PRESCALE) begin
      state_d = IDLE;
      deb_d   = '0;
    end else begin
      case (state)
        IDLE, QUAL: begin
          if (!ev_s) begin
            state_d = IDLE;
            deb_d   = '0;
          end else if (deb_at_last) begin
            state_d = RELEASE;
            deb_d   = '0;
          end else begin
            state_d = QUAL;
            deb_d   = deb_inc;
          end
        end
        RELEASE: begin
          if (ev_s) begin
            deb_d = '0;
          end else if (deb_at_last) begin
            state_d = IDLE;
            deb_d   = '0;
          end else begin
            deb_d = deb_inc;
          end
        end
        default: begin
          state_d = IDLE;
          deb_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    qual   = 1'b0;
    tick_d = 1'b0;
    div_d  = div_cnt;
    if (mode_chg) begin
      div_d = '0;
    end else if (mode == MODE_PRESCALE) begin
      if (enable) begin
        if (div_cnt == prescale) begin
          div_d  = '0;
          tick_d = 1'b1;
        end else begin
          div_d = div_cnt + PRESCALE_W'(1);
        end
      end
    end else begin
      qual   = (state == IDLE || state == QUAL) && ev_s && deb_at_last;
      tick_d = qual && enable;
    end
  end

`ifdef CEG_MISSED_EVENT_EN
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      missed <= 1'b0;
    end else if (qual && !enable) begin
      missed <= 1'b1;
    end
  end
`else
  assign missed = 1'b0;
`endif

endmodule
